// File: rtl/i2c_sram_pkg.sv
// Shared types and constants for the i2c_sram master.
package i2c_sram_pkg;

    localparam int unsigned DEV_ADDR_W = 7;
    localparam int unsigned MEM_ADDR_W = 8;
    localparam int unsigned DATA_W     = 16;

    localparam logic MODE_WRITE = 1'b0;
    localparam logic MODE_READ  = 1'b1;

    typedef enum logic [3:0] {
        StIdle, StStart, StAddr, StAddrAck, StMaddr, StMaddrAck,
        StWrHi, StWrHiAck, StWrLo, StWrLoAck,
        StRdHi, StMAck, StRdLo, StMNack, StStop, StDone
    } state_e;

    // Slots where the slave owns the ACK bit.
    function automatic logic is_slave_ack(input state_e s);
        return (s == StAddrAck) || (s == StMaddrAck) || (s == StWrHiAck) || (s == StWrLoAck);
    endfunction

    // Successor of a completed slot (full frame, no abort).
    function automatic state_e next_state(input state_e s, input logic rw);
        case (s)
            StStart:    return StAddr;
            StAddr:     return StAddrAck;
            StAddrAck:  return StMaddr;
            StMaddr:    return StMaddrAck;
            StMaddrAck: return (rw == MODE_WRITE) ? StWrHi : StRdHi;
            StWrHi:     return StWrHiAck;
            StWrHiAck:  return StWrLo;
            StWrLo:     return StWrLoAck;
            StWrLoAck:  return StStop;
            StRdHi:     return StMAck;
            StMAck:     return StRdLo;
            StRdLo:     return StMNack;
            StMNack:    return StStop;
            StStop:     return StDone;
            default:    return StIdle;
        endcase
    endfunction

endpackage

// File: rtl/i2c_quarter_timer.sv
// Divides clk into SCL quarter-phases: qtick ends each quarter, sample marks first clk of Q3.
module i2c_quarter_timer
#(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_clear,
    output logic       o_qtick,
    output logic [1:0] o_quarter,
    output logic       o_sample
);

    localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] r_cnt;
    logic [1:0]    r_quarter;
    logic          w_qtick;

    assign w_qtick   = (r_cnt == LAST);
    assign o_qtick   = w_qtick;
    assign o_quarter = r_quarter;
    assign o_sample  = (r_quarter == 2'd3) && (r_cnt == '0);

    // Quarter counter; restarts at Q0 on reset or transaction accept.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            r_cnt     <= '0;
            r_quarter <= 2'd0;
        end else if (w_qtick) begin
            r_cnt     <= '0;
            r_quarter <= r_quarter + 2'd1;
        end else begin
            r_cnt     <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/i2c_sram_master.sv
// I2C master issuing 16-bit write/read frames to the i2c_sram_embedded slave.
// Optional: define I2C_MASTER_NACK_ABORT_EN to jump to STOP right after any slave NACK.
// Bus outputs are registered from a (state, quarter) decode, so they trail the timer by one clk.
module i2c_sram_master
    import i2c_sram_pkg::*;
#(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  rw,
    input  logic [DEV_ADDR_W-1:0] dev_addr,
    input  logic [MEM_ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0]     wr_data,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  busy,
    output logic                  done,
    output logic                  ack_err,
    output logic                  scl,
    inout  wire                   sda
);

    state_e                r_state;
    logic                  r_rw;
    logic [DEV_ADDR_W-1:0] r_dev;
    logic [MEM_ADDR_W-1:0] r_maddr;
    logic [DATA_W-1:0]     r_wdata;
    logic [2:0]            r_bitcnt;
    logic [DATA_W-1:0]     r_rd_shift;
    logic [DATA_W-1:0]     r_rd_data;
    logic                  r_busy, r_done, r_ack_err, r_scl, r_sda_low;

    logic       w_accept, w_qtick, w_sample, w_slot_end, w_sda_in, w_tx_bit;
    logic [1:0] w_quarter;
    logic [7:0] w_tx_byte;
    logic       w_scl_dec, w_sda_low_dec;

    assign w_accept   = (r_state == StIdle) && start;
    assign w_slot_end = w_qtick && (w_quarter == 2'd3);
    assign w_sda_in   = sda;
    assign sda        = r_sda_low ? 1'b0 : 1'bz;

    assign rd_data = r_rd_data;
    assign busy    = r_busy;
    assign done    = r_done;
    assign ack_err = r_ack_err;
    assign scl     = r_scl;

    i2c_quarter_timer #(
        .CLK_DIV (CLK_DIV)
    ) u_timer (
        .i_clk     (clk),
        .i_reset   (reset),
        .i_clear   (w_accept),
        .o_qtick   (w_qtick),
        .o_quarter (w_quarter),
        .o_sample  (w_sample)
    );

    // Byte being transmitted in the current slot; bit counter indexes it MSB first.
    always_comb begin
        w_tx_byte = 8'h00;
        case (r_state)
            StAddr:  w_tx_byte = {r_dev, r_rw};
            StMaddr: w_tx_byte = r_maddr;
            StWrHi:  w_tx_byte = r_wdata[15:8];
            StWrLo:  w_tx_byte = r_wdata[7:0];
            default: ;
        endcase
        w_tx_bit = w_tx_byte[r_bitcnt];
    end

    // SCL/SDA levels for the current slot and quarter.
    always_comb begin
        w_scl_dec     = 1'b1;
        w_sda_low_dec = 1'b0;
        case (r_state)
            StIdle, StDone: ;
            StStart: begin
                w_scl_dec     = (w_quarter != 2'd3);
                w_sda_low_dec = w_quarter[1];
            end
            StStop: begin
                w_scl_dec     = (w_quarter != 2'd0);
                w_sda_low_dec = (w_quarter != 2'd3);
            end
            StAddr, StMaddr, StWrHi, StWrLo: begin
                w_scl_dec     = w_quarter[1];
                w_sda_low_dec = ~w_tx_bit;
            end
            StMAck: begin
                w_scl_dec     = w_quarter[1];
                w_sda_low_dec = 1'b1;
            end
            default: w_scl_dec = w_quarter[1];
        endcase
    end

    // Transaction FSM with registered bus and status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= StIdle;
            r_rw       <= MODE_WRITE;
            r_dev      <= '0;
            r_maddr    <= '0;
            r_wdata    <= '0;
            r_bitcnt   <= 3'd7;
            r_rd_shift <= '0;
            r_rd_data  <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_ack_err  <= 1'b0;
            r_scl      <= 1'b1;
            r_sda_low  <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_scl     <= w_scl_dec;
            r_sda_low <= w_sda_low_dec;
            case (r_state)
                StIdle: begin
                    if (start) begin
                        r_rw      <= rw;
                        r_dev     <= dev_addr;
                        r_maddr   <= mem_addr;
                        r_wdata   <= wr_data;
                        r_busy    <= 1'b1;
                        r_ack_err <= 1'b0;
                        r_state   <= StStart;
                    end
                end
                StDone: begin
                    r_done  <= 1'b1;
                    r_state <= StIdle;
                end
                default: begin
                    if (w_sample) begin
                        if (is_slave_ack(r_state) && w_sda_in) r_ack_err <= 1'b1;
                        if ((r_state == StRdHi) || (r_state == StRdLo)) begin
                            r_rd_shift <= {r_rd_shift[DATA_W-2:0], w_sda_in};
                        end
                    end
                    if (w_slot_end) begin
                        case (r_state)
                            StAddr, StMaddr, StWrHi, StWrLo, StRdHi, StRdLo: begin
                                if (r_bitcnt == 3'd0) r_state <= next_state(r_state, r_rw);
                                else                  r_bitcnt <= r_bitcnt - 3'd1;
                            end
                            StStop: begin
                                r_busy  <= 1'b0;
                                r_state <= StDone;
                            end
                            StMNack: begin
                                r_rd_data <= r_rd_shift;
                                r_state   <= StStop;
                            end
                            default: begin
                                r_bitcnt <= 3'd7;
                                r_state  <= next_state(r_state, r_rw);
`ifdef I2C_MASTER_NACK_ABORT_EN
                                // ack_err is still clear before the first NACK, so it flags this slot.
                                if (is_slave_ack(r_state) &&
                                    (r_ack_err || (w_sample && w_sda_in))) begin
                                    r_state <= StStop;
                                end
`endif
                            end
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_sram_master.sv
// Self-checking bench: byte-level slave model on the bus, memory reference model, timing checks.
module tb_i2c_sram_master;
    import i2c_sram_pkg::*;

    localparam int unsigned CD  = 5;
    localparam int unsigned CDF = 1;
    localparam logic [6:0] MY_ADDR = 7'h3C;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start, rw;
    logic [6:0]  dev_addr;
    logic [7:0]  mem_addr;
    logic [15:0] wr_data, rd_data;
    logic        busy, done, ack_err, scl;
    wire         sda;
    logic        s_drv = 1'b0;

    pullup (sda);
    assign sda = s_drv ? 1'b0 : 1'bz;

    logic        start_f;
    logic [15:0] rd_data_f;
    logic        busy_f, done_f, ack_err_f, scl_f;
    wire         sda_f;
    pullup (sda_f);

    i2c_sram_master #(.CLK_DIV(CD)) u_dut (
        .clk(clk), .reset(reset), .start(start), .rw(rw), .dev_addr(dev_addr),
        .mem_addr(mem_addr), .wr_data(wr_data), .rd_data(rd_data), .busy(busy),
        .done(done), .ack_err(ack_err), .scl(scl), .sda(sda)
    );

    // Second instance with no slave attached, used for CLK_DIV=1 timing.
    i2c_sram_master #(.CLK_DIV(CDF)) u_dut_fast (
        .clk(clk), .reset(reset), .start(start_f), .rw(MODE_WRITE), .dev_addr(MY_ADDR),
        .mem_addr(8'h00), .wr_data(16'h0000), .rd_data(rd_data_f), .busy(busy_f),
        .done(done_f), .ack_err(ack_err_f), .scl(scl_f), .sda(sda_f)
    );

    int n_checks = 0;
    int n_err    = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Slave on the bus (my_addr 3C): decodes START/STOP and bytes from sampled levels.
    logic [15:0] slv_mem [256];
    logic [15:0] model_mem [256];
    logic [7:0]  byte_q [$];
    logic        m_ack_q [$];
    int          start_cnt = 0, stop_cnt = 0, done_cnt = 0;
    logic        p_scl = 1'b1, p_sda = 1'b1, c_scl, c_sda;
    logic        s_active = 1'b0, s_skip = 1'b0, s_rw = 1'b0;
    int          s_bit = 0, s_byte = 0;
    logic [7:0]  s_sh = 8'h00, s_addr = 8'h00, s_hi = 8'h00;
    logic [15:0] s_tx;
    logic [15:0] exp_rd = 16'h0000;

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
        c_scl = scl;
        c_sda = sda;
        if (p_scl && c_scl && p_sda && !c_sda) begin
            start_cnt++;
            s_active = 1'b1; s_skip = 1'b1; s_bit = 0; s_byte = 0; s_rw = 1'b0; s_drv = 1'b0;
        end else if (p_scl && c_scl && !p_sda && c_sda) begin
            stop_cnt++;
            s_active = 1'b0; s_drv = 1'b0;
        end else if (s_active && !p_scl && c_scl) begin
            if (s_bit < 8) s_sh = {s_sh[6:0], c_sda};
            else if (s_rw && s_byte >= 2) m_ack_q.push_back(c_sda);
        end else if (s_active && p_scl && !c_scl) begin
            if (s_skip) begin
                s_skip = 1'b0;
            end else begin
                s_bit++;
                if (s_bit == 9) begin
                    s_bit = 0;
                    s_byte++;
                end
                if (s_bit == 8) begin
                    byte_q.push_back(s_sh);
                    case (s_byte)
                        0: begin
                            s_rw = s_sh[0];
                            if (s_sh[7:1] == MY_ADDR) s_drv = 1'b1;
                            else begin s_drv = 1'b0; s_active = 1'b0; end
                        end
                        1: begin s_addr = s_sh; s_drv = 1'b1; end
                        2: begin
                            if (!s_rw) begin s_hi = s_sh; s_drv = 1'b1; end
                            else s_drv = 1'b0;
                        end
                        3: begin
                            if (!s_rw) begin slv_mem[s_addr] = {s_hi, s_sh}; s_drv = 1'b1; end
                            else s_drv = 1'b0;
                        end
                        default: s_drv = 1'b0;
                    endcase
                end else if (s_rw && (s_byte == 2 || s_byte == 3)) begin
                    s_tx  = slv_mem[s_addr];
                    s_drv = ~s_tx[((s_byte == 2) ? 15 : 7) - s_bit];
                end else begin
                    s_drv = 1'b0;
                end
            end
        end
        p_scl = c_scl;
        p_sda = c_sda;
    end

    task automatic run_check(input logic t_rw, input logic [6:0] t_dev, input logic [7:0] t_maddr,
                             input logic [15:0] t_wdata, input bit glitch);
        logic [7:0]  exp_b [$];
        logic [15:0] word;
        bit          match;
        int          lat, exp_lat, d0, st0, sp0;
        match = (t_dev == MY_ADDR);
        word  = (t_rw == MODE_READ) ? model_mem[t_maddr] : t_wdata;
        exp_b.push_back({t_dev, t_rw});
        if (match) begin
            exp_b.push_back(t_maddr);
            exp_b.push_back(word[15:8]);
            exp_b.push_back(word[7:0]);
        end
        exp_lat = 152 * CD + 1;
`ifdef I2C_MASTER_NACK_ABORT_EN
        if (!match) exp_lat = 44 * CD + 1;
`endif
        byte_q.delete();
        m_ack_q.delete();
        d0 = done_cnt; st0 = start_cnt; sp0 = stop_cnt;
        @(negedge clk);
        rw = t_rw; dev_addr = t_dev; mem_addr = t_maddr; wr_data = t_wdata; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check_eq("busy_on", busy, 1);
        lat = 0;
        while (1'b1) begin
            @(posedge clk); #1;
            lat++;
            if (done) break;
            if (glitch && lat == 100) begin
                start = 1'b1; rw = ~t_rw;
                dev_addr = 7'($urandom); mem_addr = 8'($urandom); wr_data = 16'($urandom);
            end
            if (glitch && lat == 101) start = 1'b0;
            if (lat > 200 * CD) break;
        end
        check_eq("latency", lat, exp_lat);
        check_eq("ack_err", ack_err, !match);
        check_eq("busy_off", busy, 0);
        repeat (2) @(negedge clk);
        check_eq("done_pulse", done, 0);
        check_eq("done_cnt", done_cnt - d0, 1);
        check_eq("start_cnt", start_cnt - st0, 1);
        check_eq("stop_cnt", stop_cnt - sp0, 1);
        check_eq("nbytes", byte_q.size(), exp_b.size());
        for (int i = 0; i < exp_b.size(); i++) begin
            if (i < byte_q.size()) check_eq($sformatf("byte%0d", i), byte_q[i], exp_b[i]);
        end
        if (match && t_rw == MODE_READ) begin
            exp_rd = word;
            check_eq("m_ack_n", m_ack_q.size(), 2);
            if (m_ack_q.size() == 2) begin
                check_eq("m_ack_hi", m_ack_q[0], 0);
                check_eq("m_nack_lo", m_ack_q[1], 1);
            end
        end
        if (match && t_rw == MODE_WRITE) begin
            model_mem[t_maddr] = t_wdata;
            check_eq("sram", slv_mem[t_maddr], t_wdata);
        end
        check_eq("rd_data", rd_data, exp_rd);
    endtask

    initial begin
        logic [7:0]  ra;
        logic        rr;
        int          lat, exp_lat, d0;
        for (int i = 0; i < 256; i++) begin
            slv_mem[i]   = 16'h0000;
            model_mem[i] = 16'h0000;
        end
        reset = 1'b1; start = 1'b0; start_f = 1'b0; rw = MODE_WRITE;
        dev_addr = 7'h00; mem_addr = 8'h00; wr_data = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_scl", scl, 1);
        check_eq("rst_sda", sda, 1);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_ack_err", ack_err, 0);
        check_eq("rst_rd_data", rd_data, 16'h0000);
        check_eq("rst_fast_scl", scl_f, 1);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        run_check(MODE_WRITE, 7'h3C, 8'h7C, 16'h5093, 1'b0);
        run_check(MODE_WRITE, 7'h3C, 8'h7C, 16'd1234, 1'b0);
        run_check(MODE_READ,  7'h3C, 8'h7C, 16'h0000, 1'b0);
        run_check(MODE_WRITE, 7'h3D, 8'h10, 16'hCAFE, 1'b0);
        run_check(MODE_WRITE, 7'h3C, 8'h22, 16'hBEEF, 1'b1);

        // Reset while MADDR bit 3 is on the bus.
        d0 = done_cnt;
        @(negedge clk);
        rw = MODE_READ; dev_addr = MY_ADDR; mem_addr = 8'h7C; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (58 * CD) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check_eq("midrst_scl", scl, 1);
        check_eq("midrst_sda", sda, 1);
        check_eq("midrst_busy", busy, 0);
        check_eq("midrst_rd", rd_data, 16'h0000);
        @(negedge clk);
        reset = 1'b0;
        check_eq("midrst_nodone", done_cnt - d0, 0);
        exp_rd = 16'h0000;
        repeat (3) @(negedge clk);
        run_check(MODE_WRITE, 7'h3C, 8'h7C, 16'hA5A5, 1'b0);
        run_check(MODE_READ,  7'h3C, 8'h7C, 16'h0000, 1'b0);

        for (int k = 0; k < 6; k++) begin
            case ($urandom_range(0, 2))
                0:       ra = 8'h10;
                1:       ra = 8'h22;
                default: ra = 8'h7C;
            endcase
            rr = 1'($urandom);
            run_check(rr, MY_ADDR, ra, 16'($urandom), 1'b0);
        end

        // CLK_DIV=1 instance, no slave: every ACK slot reads 1.
        exp_lat = 152 * CDF + 1;
`ifdef I2C_MASTER_NACK_ABORT_EN
        exp_lat = 44 * CDF + 1;
`endif
        @(negedge clk);
        start_f = 1'b1;
        @(posedge clk); #1;
        start_f = 1'b0;
        lat = 0;
        while (1'b1) begin
            @(posedge clk); #1;
            lat++;
            if (done_f || lat > 400) break;
        end
        check_eq("fast_latency", lat, exp_lat);
        check_eq("fast_ack_err", ack_err_f, 1);
        check_eq("fast_busy", busy_f, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
